// File: rtl/wave_pkg.sv
// wave_pkg: shared constants and sample-to-row mapping for the waveform renderers
package wave_pkg;
  localparam int RGB_W = 8;
  localparam int H_RES = 1280;
  localparam int V_RES = 1024;
  localparam int ROW_W = 11;
  localparam logic [RGB_W-1:0] GRID_GREY = 8'h40;
  function automatic logic [ROW_W-1:0] sample_to_row(input logic [15:0] sample, input int y_offset, input int y_shift);
    return ROW_W'(y_offset) + ROW_W'(sample >> y_shift);
  endfunction
endpackage

// File: rtl/trace_span_hit.sv
// trace_span_hit: per-channel previous-row register and vertical span compare
module trace_span_hit import wave_pkg::*; #(
  parameter int SAMPLE_W = 8,
  parameter int Y_OFFSET = 0,
  parameter int Y_SHIFT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                load,
  input  logic                first,
  input  logic                active,
  input  logic [9:0]          y,
  output logic                hit
);
  logic [ROW_W-1:0] cur_row, prev_row, ref_row, lo, hi;
  assign cur_row = sample_to_row(16'(sample), Y_OFFSET, Y_SHIFT);
  // the first column of a line must not connect back to the previous scanline
  assign ref_row = first ? cur_row : prev_row;
  assign lo = ref_row < cur_row ? ref_row : cur_row;
  assign hi = ref_row < cur_row ? cur_row : ref_row;
  assign hit = active && {1'b0, y} >= lo && {1'b0, y} <= hi;
  always_ff @(posedge clk or negedge reset)
    if (!reset) prev_row <= '0;
    else if (load) prev_row <= cur_row;
endmodule

// File: rtl/wave_display_multi.sv
// wave_display_multi: renders NUM_CH overlaid sample traces plus graticule onto the raster scan
module wave_display_multi import wave_pkg::*; #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int IDX_W    = 8,
  parameter int X_START  = 256,
  parameter int X_SHIFT  = 1,
  parameter int Y_OFFSET = 0,
  parameter int Y_SHIFT  = 1,
  parameter logic [NUM_CH*24-1:0] CH_COLORS = 48'hFFFF00_00FF00,
  parameter int GRID_X   = 6,
  parameter int GRID_Y   = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         grid_en,
  output logic [IDX_W:0]               read_address,
  input  logic [NUM_CH*SAMPLE_W-1:0]   read_value,
  output logic                         valid_pixel,
  output logic [RGB_W-1:0]             r,
  output logic [RGB_W-1:0]             g,
  output logic [RGB_W-1:0]             b
);
  localparam logic [11:0] X_LO = 12'(X_START);
  localparam logic [11:0] X_HI = 12'(X_START + 2**(IDX_W+X_SHIFT));
  logic              active_bank, in_win, in_win_s1, first_s1, load, grid;
  logic [11:0]       x_off;
  logic [IDX_W-1:0]  idx, idx_s1, last_idx;
  logic [9:0]        y_s1;
  logic [GRID_X-1:0] gx_s1;
  logic [NUM_CH-1:0] hit;
  logic [23:0]       color;
  assign x_off = {1'b0, x} - X_LO;
  assign in_win = valid && {1'b0, x} >= X_LO && {1'b0, x} < X_HI;
  assign idx = IDX_W'(x_off >> X_SHIFT);
  assign read_address = {active_bank, idx};
  assign load = in_win_s1 && (first_s1 || idx_s1 != last_idx);
  assign grid = grid_en && in_win_s1 && (gx_s1 == '0 || y_s1[GRID_Y-1:0] == '0);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    trace_span_hit #(.SAMPLE_W(SAMPLE_W), .Y_OFFSET(Y_OFFSET), .Y_SHIFT(Y_SHIFT)) u_hit (
      .clk(clk), .reset(reset), .sample(read_value[c*SAMPLE_W +: SAMPLE_W]), .load(load),
      .first(first_s1), .active(ch_enable[c] && in_win_s1), .y(y_s1), .hit(hit[c]));
  end
  // lowest-numbered hitting channel wins
  always_comb begin
    color = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) color = hit[c] ? CH_COLORS[c*24 +: 24] : color;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      active_bank <= 1'b0;
      y_s1 <= '0;
      in_win_s1 <= 1'b0;
      idx_s1 <= '0;
      first_s1 <= 1'b0;
      gx_s1 <= '0;
      last_idx <= '0;
      valid_pixel <= 1'b0;
      {r, g, b} <= '0;
    end else begin
      if (valid && x == '0 && y == '0) active_bank <= read_index;
      y_s1 <= y;
      in_win_s1 <= in_win;
      idx_s1 <= idx;
      first_s1 <= {1'b0, x} == X_LO;
      gx_s1 <= x_off[GRID_X-1:0];
      if (load) last_idx <= idx_s1;
      valid_pixel <= |hit || grid;
      {r, g, b} <= |hit ? color : grid ? {3{GRID_GREY}} : '0;
    end
endmodule

// File: tb/tb_wave_display_multi.sv
// tb_wave_display_multi: directed and randomized checks against a geometric trace model
module tb_wave_display_multi;
  localparam int X0 = 256;
  typedef struct {logic [10:0] x; logic [9:0] y; logic v; logic ri; logic [1:0] ce; logic ge;} px_t;
  logic clk = 1'b0, reset, valid, read_index, grid_en, valid_pixel;
  logic [10:0] x;
  logic [9:0] y;
  logic [1:0] ch_enable;
  logic [8:0] read_address;
  logic [15:0] read_value;
  logic [7:0] r, g, b;
  logic [15:0] mem [512];
  int vecs = 0, miss = 0;

  wave_display_multi dut (.clk(clk), .reset(reset), .x(x), .y(y), .valid(valid), .read_index(read_index),
    .ch_enable(ch_enable), .grid_en(grid_en), .read_address(read_address), .read_value(read_value),
    .valid_pixel(valid_pixel), .r(r), .g(g), .b(b));

  always #5 clk = ~clk;
  always @(posedge clk) read_value <= mem[read_address];

  // A trace is drawn as a vertical segment from the previous sample's row to this sample's row
  // on the first column of each sample; other columns light only the sample's own row.
  function automatic logic [24:0] model(input int px, input int py, input logic pv, input logic bk,
                                        input logic [1:0] ce, input logic ge);
    int off, i, cur, prv;
    logic [24:0] res;
    res = '0;
    off = px - X0;
    if (pv && px >= X0 && px < X0 + 512) begin
      i = off / 2;
      if (ge && (off % 64 == 0 || py % 32 == 0)) res = {1'b1, 24'h404040};
      for (int c = 1; c >= 0; c--) begin
        cur = int'(mem[int'(bk) * 256 + i][c*8 +: 8]) / 2;
        prv = (off % 2 == 0 && off != 0) ? int'(mem[int'(bk) * 256 + i - 1][c*8 +: 8]) / 2 : cur;
        if (ce[c] && py >= (prv < cur ? prv : cur) && py <= (prv < cur ? cur : prv))
          res = {1'b1, c == 0 ? 24'h00FF00 : 24'hFFFF00};
      end
    end
    return res;
  endfunction

  task automatic drive_run(input int x0, input int x1, input int yy);
    for (int i = x0; i <= x1; i++) begin
      @(negedge clk);
      x = 11'(i);
      y = 10'(yy);
      valid = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vecs++;
    if ({valid_pixel, r, g, b} !== 25'd0) begin
      miss++; $display("FAIL reset_out got %h exp 0", {valid_pixel, r, g, b});
    end
    vecs++;
    if (read_address[8] !== 1'b0) begin
      miss++; $display("FAIL reset_bank got %b exp 0", read_address[8]);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_addressing();
    logic [24:0] o;
    ch_enable = 2'b00;
    grid_en = 1'b1;
    drive_run(256, 256, 0); #1;
    vecs++;
    if (read_address !== 9'd0) begin miss++; $display("FAIL addr_256 got %0d exp 0", read_address); end
    drive_run(511, 511, 0); #1;
    vecs++;
    if (read_address !== 9'd127) begin miss++; $display("FAIL addr_511 got %0d exp 127", read_address); end
    drive_run(767, 767, 0); #1;
    vecs++;
    if (read_address !== 9'd255) begin miss++; $display("FAIL addr_767 got %0d exp 255", read_address); end
    idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== {1'b1, 24'h404040}) begin miss++; $display("FAIL grid_767 got %h exp 1404040", o); end
    drive_run(768, 768, 0); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== 25'd0) begin miss++; $display("FAIL outside_768 got %h exp 0", o); end
    grid_en = 1'b0;
  endtask

  task automatic test_bank_latch();
    read_index = 1'b1;
    drive_run(490, 490, 200); idle(); #1;
    vecs++;
    if (read_address[8] !== 1'b0) begin miss++; $display("FAIL bank_midframe got %b exp 0", read_address[8]); end
    drive_run(0, 0, 0);
    @(negedge clk); #1;
    vecs++;
    if (read_address[8] !== 1'b1) begin miss++; $display("FAIL bank_latch got %b exp 1", read_address[8]); end
    read_index = 1'b0;
    drive_run(0, 0, 0); idle();
    vecs++;
    if (read_address[8] !== 1'b0) begin miss++; $display("FAIL bank_back got %b exp 0", read_address[8]); end
  endtask

  task automatic test_line_span();
    logic [24:0] o;
    ch_enable = 2'b01;
    grid_en = 1'b0;
    drive_run(252, 276, 60); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== {1'b1, 24'h00FF00}) begin miss++; $display("FAIL span_y60 got %h exp 100ff00", o); end
    drive_run(252, 276, 71); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== 25'd0) begin miss++; $display("FAIL span_y71 got %h exp 0", o); end
  endtask

  task automatic test_priority_enable();
    logic [24:0] o;
    mem[9][15:8] = 8'd100;
    mem[10][15:8] = 8'd140;
    ch_enable = 2'b11;
    drive_run(252, 276, 60); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== {1'b1, 24'h00FF00}) begin miss++; $display("FAIL prio_both got %h exp 100ff00", o); end
    ch_enable = 2'b10;
    drive_run(252, 276, 60); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== {1'b1, 24'hFFFF00}) begin miss++; $display("FAIL prio_ch1 got %h exp 1ffff00", o); end
    ch_enable = 2'b00;
    drive_run(252, 276, 60); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== 25'd0) begin miss++; $display("FAIL prio_none got %h exp 0", o); end
    mem[9][15:8] = 8'd200;
    mem[10][15:8] = 8'd200;
  endtask

  task automatic test_grid_first();
    logic [24:0] o;
    ch_enable = 2'b11;
    grid_en = 1'b1;
    drive_run(252, 320, 5); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== {1'b1, 24'h404040}) begin miss++; $display("FAIL grid_320 got %h exp 1404040", o); end
    ch_enable = 2'b01;
    grid_en = 1'b0;
    drive_run(252, 276, 40);
    drive_run(252, 256, 40); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== 25'd0) begin miss++; $display("FAIL first_y40 got %h exp 0", o); end
    drive_run(252, 256, 30); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== {1'b1, 24'h00FF00}) begin miss++; $display("FAIL first_y30 got %h exp 100ff00", o); end
    drive_run(252, 256, 31); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== 25'd0) begin miss++; $display("FAIL first_y31 got %h exp 0", o); end
  endtask

  task automatic test_async_reset();
    logic [24:0] o;
    mem[256 + 9][7:0] = 8'd100;
    mem[256 + 10][7:0] = 8'd140;
    ch_enable = 2'b01;
    grid_en = 1'b0;
    read_index = 1'b1;
    drive_run(0, 0, 0);
    drive_run(252, 276, 60); idle(); idle();
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== {1'b1, 24'h00FF00} || read_address[8] !== 1'b1) begin
      miss++; $display("FAIL bank1_lit got %h/%b exp 100ff00/1", o, read_address[8]);
    end
    #2 reset = 1'b0;
    #1;
    o = {valid_pixel, r, g, b};
    vecs++;
    if (o !== 25'd0) begin miss++; $display("FAIL async_out got %h exp 0", o); end
    vecs++;
    if (read_address[8] !== 1'b0) begin miss++; $display("FAIL async_bank got %b exp 0", read_address[8]); end
    @(negedge clk);
    reset = 1'b1;
    read_index = 1'b0;
  endtask

  task automatic test_random();
    px_t st[$];
    logic [24:0] q[$];
    logic [24:0] e;
    logic bk, ri, ge;
    logic [1:0] ce;
    int n;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    for (int run_i = 0; run_i < 30; run_i++) begin
      ri = 1'($urandom);
      ce = 2'($urandom);
      ge = 1'($urandom);
      n = $urandom_range(8, 530);
      st.push_back('{11'd0, 10'd0, 1'b1, ri, ce, ge});
      for (int k = 0; k < n; k++)
        st.push_back('{11'(252 + k), ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                                 : 10'($urandom_range(0, 140)), 1'b1, ri, ce, ge});
      repeat (2) st.push_back('{11'd0, 10'd5, 1'b0, ri, ce, ge});
    end
    bk = 1'b0;
    for (int k = 0; k < st.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        e = q.pop_front();
        vecs++;
        if ({valid_pixel, r, g, b} !== e) begin
          miss++; $display("FAIL random_px%0d got %h exp %h", k - 2, {valid_pixel, r, g, b}, e);
        end
      end
      if (k < st.size()) begin
        x = st[k].x;
        y = st[k].y;
        valid = st[k].v;
        read_index = st[k].ri;
        ch_enable = st[k].ce;
        grid_en = st[k].ge;
        if (st[k].v && st[k].x == 11'd0 && st[k].y == 10'd0) bk = st[k].ri;
        q.push_back(model(int'(st[k].x), int'(st[k].y), st[k].v, bk, st[k].ce, st[k].ge));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {8'd200, 8'd0};
    mem[0][7:0] = 8'd60;
    mem[9][7:0] = 8'd100;
    mem[10][7:0] = 8'd140;
    reset = 1'b0;
    x = '0;
    y = '0;
    valid = 1'b0;
    read_index = 1'b0;
    ch_enable = 2'b00;
    grid_en = 1'b0;
    test_reset();
    test_addressing();
    test_bank_latch();
    test_line_span();
    test_priority_enable();
    test_grid_first();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
